// File: rtl/ram_arbiter_2x_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_arbiter_2x_if : two-client request bus plus the RAM port side.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface ram_arbiter_2x_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  c0_req;
  logic                  c0_we;
  logic [ADDR_WIDTH-1:0] c0_addr;
  logic [RAM_WIDTH-1:0]  c0_wdata;
  logic                  c0_gnt;
  logic                  c0_rvalid;
  logic [RAM_WIDTH-1:0]  c0_rdata;

  logic                  c1_req;
  logic                  c1_we;
  logic [ADDR_WIDTH-1:0] c1_addr;
  logic [RAM_WIDTH-1:0]  c1_wdata;
  logic                  c1_gnt;
  logic                  c1_rvalid;
  logic [RAM_WIDTH-1:0]  c1_rdata;

  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]  data_in;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]  data_out;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    input  data_out,
    output c0_gnt, c0_rvalid, c0_rdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output wr_enb, wr_addr, data_in, rd_enb, rd_addr
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    output data_out,
    input  c0_gnt, c0_rvalid, c0_rdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  wr_enb, wr_addr, data_in, rd_enb, rd_addr
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_2x.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_arbiter_2x : round-robin write/read arbiter for two RAM clients.|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ram_arbiter_2x #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ram_arbiter_2x_if.slave bus
);

  generate
    if (RAM_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_mismatch
      $error("RAM_DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic                  r_wr_prio;
  logic                  r_rd_prio;
  logic                  r_rd_tag1;
  logic                  r_rd_vld2;
  logic                  r_rd_tag2;

  logic                  w_wr0, w_wr1, w_rd0, w_rd1;
  logic                  w_wr_gnt0, w_wr_gnt1, w_wr_any;
  logic                  w_rd_win0, w_rd_win1;
  logic                  w_rd_gnt0, w_rd_gnt1, w_rd_any;
  logic                  w_hazard;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [RAM_WIDTH-1:0]  w_wr_data;

  assign w_wr0 = bus.c0_req &  bus.c0_we;
  assign w_wr1 = bus.c1_req &  bus.c1_we;
  assign w_rd0 = bus.c0_req & ~bus.c0_we;
  assign w_rd1 = bus.c1_req & ~bus.c1_we;

  // Priority bit set means client 1 wins a contested channel.
  assign w_wr_gnt0 = rst & w_wr0 & (~w_wr1 | ~r_wr_prio);
  assign w_wr_gnt1 = rst & w_wr1 & (~w_wr0 |  r_wr_prio);
  assign w_rd_win0 = rst & w_rd0 & (~w_rd1 | ~r_rd_prio);
  assign w_rd_win1 = rst & w_rd1 & (~w_rd0 |  r_rd_prio);

  assign w_wr_any  = w_wr_gnt0 | w_wr_gnt1;
  assign w_wr_addr = w_wr_gnt1 ? bus.c1_addr  : bus.c0_addr;
  assign w_wr_data = w_wr_gnt1 ? bus.c1_wdata : bus.c0_wdata;
  assign w_rd_addr = w_rd_win1 ? bus.c1_addr  : bus.c0_addr;

  // A same-cycle read of the address being written waits one cycle.
  assign w_hazard  = w_wr_any & (w_rd_win0 | w_rd_win1) & (w_wr_addr == w_rd_addr);
  assign w_rd_gnt0 = w_rd_win0 & ~w_hazard;
  assign w_rd_gnt1 = w_rd_win1 & ~w_hazard;
  assign w_rd_any  = w_rd_gnt0 | w_rd_gnt1;

  assign bus.c0_gnt = w_wr_gnt0 | w_rd_gnt0;
  assign bus.c1_gnt = w_wr_gnt1 | w_rd_gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_prio     <= 1'b0;
      r_rd_prio     <= 1'b0;
      r_rd_tag1     <= 1'b0;
      r_rd_vld2     <= 1'b0;
      r_rd_tag2     <= 1'b0;
      bus.wr_enb    <= 1'b0;
      bus.wr_addr   <= '0;
      bus.data_in   <= '0;
      bus.rd_enb    <= 1'b0;
      bus.rd_addr   <= '0;
      bus.c0_rvalid <= 1'b0;
      bus.c1_rvalid <= 1'b0;
      bus.c0_rdata  <= '0;
      bus.c1_rdata  <= '0;
    end else begin
      bus.wr_enb <= w_wr_any;
      if (w_wr_any) begin
        bus.wr_addr <= w_wr_addr;
        bus.data_in <= w_wr_data;
        r_wr_prio   <= w_wr_gnt0;
      end

      bus.rd_enb <= w_rd_any;
      if (w_rd_any) begin
        bus.rd_addr <= w_rd_addr;
        r_rd_prio   <= w_rd_gnt0;
      end

      // Client tag travels alongside rd_enb until data_out is captured.
      r_rd_tag1     <= w_rd_gnt1;
      r_rd_vld2     <= bus.rd_enb;
      r_rd_tag2     <= r_rd_tag1;
      bus.c0_rvalid <= r_rd_vld2 & ~r_rd_tag2;
      bus.c1_rvalid <= r_rd_vld2 &  r_rd_tag2;
      if (r_rd_vld2 && !r_rd_tag2) bus.c0_rdata <= bus.data_out;
      if (r_rd_vld2 &&  r_rd_tag2) bus.c1_rdata <= bus.data_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2x.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram_arbiter_2x : vectors, random traffic and a transaction model.|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_ram_arbiter_2x;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;

  always #5 clk = ~clk;

  ram_arbiter_2x_if #(.RAM_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_arbiter_2x #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Simple synchronous RAM: one-cycle read latency.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      bus.data_out <= '0;
    end else begin
      if (bus.wr_enb) ram[bus.wr_addr] <= bus.data_in;
      if (bus.rd_enb) bus.data_out <= ram[bus.rd_addr];
    end
  end

  typedef struct {
    bit         q0; bit w0; logic [3:0] a0; logic [7:0] d0;
    bit         q1; bit w1; logic [3:0] a1; logic [7:0] d1;
    bit         g0; bit g1;
  } vec_t;

  typedef struct {
    int         due;
    int         cl;
    logic [7:0] data;
  } rd_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  bit         cq [2];
  bit         cw [2];
  logic [3:0] ca [2];
  logic [7:0] cd [2];

  int         m_wr_prio, m_rd_prio;
  logic [7:0] m_mem [16];
  logic       e_wr_enb, e_rd_enb;
  logic [3:0] e_wr_addr, e_rd_addr;
  logic [7:0] e_data_in;
  logic [7:0] e_rdata [2];
  rd_t        pend [$];
  vec_t       tab [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic drive();
    bus.c0_req = cq[0]; bus.c0_we = cw[0]; bus.c0_addr = ca[0]; bus.c0_wdata = cd[0];
    bus.c1_req = cq[1]; bus.c1_we = cw[1]; bus.c1_addr = ca[1]; bus.c1_wdata = cd[1];
  endtask

  task automatic set_cl(input int c, input bit q, input bit w, input logic [3:0] a, input logic [7:0] d);
    cq[c] = q; cw[c] = w; ca[c] = a; cd[c] = d;
  endtask

  task automatic model_reset();
    m_wr_prio = 0; m_rd_prio = 0;
    e_wr_enb = 0; e_rd_enb = 0; e_wr_addr = '0; e_rd_addr = '0; e_data_in = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    pend.delete();
  endtask

  function automatic logic [63:0] all_out();
    return {26'd0, bus.c0_gnt, bus.c1_gnt, bus.c0_rvalid, bus.c1_rvalid, bus.wr_enb, bus.rd_enb,
            bus.wr_addr, bus.rd_addr, bus.data_in, bus.c0_rdata, bus.c1_rdata};
  endfunction

  // One clock cycle: grants checked mid-cycle, registered outputs just after the edge.
  task automatic cycle(input bit use_tab, input bit tg0, input bit tg1, output bit g0, output bit g1);
    int  wg, rg;
    bit  rv0, rv1;
    drive();
    @(negedge clk);
    wg = -1;
    if (cq[0] && cw[0] && cq[1] && cw[1]) wg = m_wr_prio;
    else if (cq[0] && cw[0]) wg = 0;
    else if (cq[1] && cw[1]) wg = 1;
    rg = -1;
    if (cq[0] && !cw[0] && cq[1] && !cw[1]) rg = m_rd_prio;
    else if (cq[0] && !cw[0]) rg = 0;
    else if (cq[1] && !cw[1]) rg = 1;
    if (wg >= 0 && rg >= 0 && ca[wg] == ca[rg]) rg = -1;
    g0 = (wg == 0) || (rg == 0);
    g1 = (wg == 1) || (rg == 1);
    chk("c0_gnt", bus.c0_gnt, g0);
    chk("c1_gnt", bus.c1_gnt, g1);
    if (use_tab) begin
      chk("vec_c0_gnt", bus.c0_gnt, tg0);
      chk("vec_c1_gnt", bus.c1_gnt, tg1);
    end
    e_wr_enb = (wg >= 0);
    e_rd_enb = (rg >= 0);
    if (rg >= 0) begin
      e_rd_addr = ca[rg];
      m_rd_prio = 1 - rg;
      pend.push_back('{due: cyc + 3, cl: rg, data: m_mem[ca[rg]]});
    end
    if (wg >= 0) begin
      e_wr_addr = ca[wg];
      e_data_in = cd[wg];
      m_wr_prio = 1 - wg;
      m_mem[ca[wg]] = cd[wg];
    end
    @(posedge clk);
    #1;
    cyc++;
    rv0 = 0; rv1 = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].cl == 0) rv0 = 1; else rv1 = 1;
      e_rdata[pend[0].cl] = pend[0].data;
      void'(pend.pop_front());
    end
    chk("wr_enb", bus.wr_enb, e_wr_enb);
    chk("wr_addr", bus.wr_addr, e_wr_addr);
    chk("data_in", bus.data_in, e_data_in);
    chk("rd_enb", bus.rd_enb, e_rd_enb);
    chk("rd_addr", bus.rd_addr, e_rd_addr);
    chk("c0_rvalid", bus.c0_rvalid, rv0);
    chk("c1_rvalid", bus.c1_rvalid, rv1);
    chk("c0_rdata", bus.c0_rdata, e_rdata[0]);
    chk("c1_rdata", bus.c1_rdata, e_rdata[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit g0, g1;
    bit gl [2];

    //            q0 w0 a0    d0      q1 w1 a1     d1      g0 g1
    tab[0]  = '{1, 1, 4'h0, 8'h11, 1, 1, 4'h1, 8'h22, 1, 0};
    tab[1]  = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h1, 8'h22, 0, 1};
    tab[2]  = '{1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, 1, 0};
    tab[3]  = '{1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0};
    tab[4]  = '{1, 1, 4'h8, 8'h44, 1, 1, 4'h9, 8'h55, 0, 1};
    tab[5]  = '{1, 1, 4'h8, 8'h44, 1, 1, 4'hA, 8'h66, 1, 0};
    tab[6]  = '{1, 1, 4'h5, 8'h3C, 1, 0, 4'h5, 8'h00, 1, 0};
    tab[7]  = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00, 0, 1};
    tab[8]  = '{1, 0, 4'h2, 8'h00, 1, 1, 4'h7, 8'h77, 1, 1};
    tab[9]  = '{1, 0, 4'h3, 8'h00, 1, 0, 4'h5, 8'h00, 0, 1};
    tab[10] = '{1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0};
    tab[11] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0};

    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    model_reset();

    // Reset held with random client activity: everything stays quiet.
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 2; c++)
        set_cl(c, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      drive();
      @(negedge clk);
      chk("reset_outputs", all_out(), 64'd0);
      @(posedge clk);
      #1;
    end
    ram_clr = 1'b0;
    for (int c = 0; c < 2; c++) set_cl(c, 0, 0, 4'h0, 8'h00);
    rst = 1'b1;
    cyc = 0;

    for (int i = 0; i < 12; i++) begin
      set_cl(0, tab[i].q0, tab[i].w0, tab[i].a0, tab[i].d0);
      set_cl(1, tab[i].q1, tab[i].w1, tab[i].a1, tab[i].d1);
      cycle(1, tab[i].g0, tab[i].g1, g0, g1);
    end

    // Both clients writing continuously: strict alternation starting at c0.
    for (int i = 0; i < 6; i++) begin
      set_cl(0, 1, 1, 4'($urandom), 8'($urandom));
      set_cl(1, 1, 1, 4'($urandom), 8'($urandom));
      cycle(1, (i % 2) == 0, (i % 2) == 1, g0, g1);
    end
    for (int c = 0; c < 2; c++) set_cl(c, 0, 0, 4'h0, 8'h00);
    repeat (5) cycle(0, 0, 0, g0, g1);

    // Random traffic on a narrow address range to provoke hazards.
    gl[0] = 1; gl[1] = 1;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 2; c++)
        if (!cq[c] || gl[c])
          set_cl(c, $urandom_range(0, 2) != 0, 1'($urandom),
                 4'($urandom_range(0, 3)), 8'($urandom));
      cycle(0, 0, 0, gl[0], gl[1]);
    end
    for (int c = 0; c < 2; c++) set_cl(c, 0, 0, 4'h0, 8'h00);
    repeat (5) cycle(0, 0, 0, g0, g1);

    // Reset two cycles after a c1 read grant discards that read.
    set_cl(1, 1, 0, 4'h5, 8'h00);
    cycle(0, 0, 0, g0, g1);
    set_cl(1, 0, 0, 4'h0, 8'h00);
    cycle(0, 0, 0, g0, g1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_outputs", all_out(), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_c1_rvalid", bus.c1_rvalid, 1'b0);
    rst = 1'b1;
    cyc = cyc + 2;
    repeat (6) cycle(0, 0, 0, g0, g1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
